// File: rtl/lm70_spi_frame_reader.sv
// -----------------------------------------------------------------------------
// lm70_spi_frame_reader
//
// SPI master front end for the LM70 temperature sensor. It generates CS and
// SCK, shifts one frame in MSB-first, and turns the 11-bit two's complement
// temperature field (0.25 C per LSB) into a sign plus a whole-degree magnitude.
// The magnitude is clamped at 99 for the two-digit display path. A one-cycle
// TEMP_VALID strobe marks each update of RAW and TEMP_*.
//
// Parameters
//   CLK_DIV     SYSCLK cycles per SCK half-period (>= 1)
//   FRAME_BITS  SCK pulses per frame (16 for the LM70 format)
//   GAP_CYCLES  SYSCLK cycles spent in GAP with CS high between frames (>= 1)
//
// Ports
//   SYSCLK      in   system clock, rising edge
//   RSTN        in   asynchronous active-low reset
//   EN          in   1 = sample continuously, 0 = stop after the current frame
//   SIO         in   serial data from the sensor
//   CS          out  chip select, active-low
//   SCK         out  serial clock, idle low
//   BUSY        out  high whenever the sequencer is not idle
//   RAW         out  last complete frame, bit 15 = first bit received
//   TEMP_NEG    out  1 = temperature below zero
//   TEMP_MAG    out  |temperature| in whole degrees C, 0..99
//   TEMP_SAT    out  1 = magnitude exceeded 99 and was clamped
//   TEMP_VALID  out  one-cycle strobe, RAW/TEMP_* updated this cycle
// -----------------------------------------------------------------------------
module lm70_spi_frame_reader #(
    parameter int CLK_DIV    = 2,
    parameter int FRAME_BITS = 16,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        SYSCLK,
    input  logic        RSTN,
    input  logic        EN,
    input  logic        SIO,
    output logic        CS,
    output logic        SCK,
    output logic        BUSY,
    output logic [15:0] RAW,
    output logic        TEMP_NEG,
    output logic [6:0]  TEMP_MAG,
    output logic        TEMP_SAT,
    output logic        TEMP_VALID
);

    localparam int RAW_W   = 16;
    // One shared phase counter times both the SCK half-periods and the gap.
    localparam int CNT_MAX = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(FRAME_BITS);
    localparam logic [6:0]       MAG_MAX  = 7'd99;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SCK_LO,
        S_SCK_HI,
        S_HOLD,
        S_CONVERT,
        S_GAP
    } state_t;

    // -------------------------------------------------------------------------
    // Conversion helpers: clamp and sign rules for the display path
    // -------------------------------------------------------------------------
    function automatic logic f_sat_flag(input logic [11:0] m);
        return (m > 12'd99);
    endfunction

    function automatic logic [6:0] f_sat_mag(input logic [11:0] m);
        return (m > 12'd99) ? MAG_MAX : m[6:0];
    endfunction

    // A reading that truncates to zero degrees is shown as +0, never -0.
    function automatic logic f_sign(input logic s, input logic [11:0] m);
        return s & (m != 12'd0);
    endfunction

    // -------------------------------------------------------------------------
    // Registers and wires
    // -------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BIT_W-1:0]   r_bitcnt;
    logic [RAW_W-1:0]   r_shift;

    logic               w_div_done;
    logic               w_shift_en;
    logic               w_bit_inc;
    logic               w_load;

    logic               r_cs;
    logic               r_sck;
    logic               r_busy;
    logic [RAW_W-1:0]   r_raw;
    logic               r_neg;
    logic [6:0]         r_mag;
    logic               r_sat;
    logic               r_valid;

    logic signed [10:0] w_r;
    logic signed [11:0] w_r_ext;
    logic signed [11:0] w_a;
    logic [11:0]        w_m;

    // -------------------------------------------------------------------------
    // Temperature conversion from the completed shift register
    // -------------------------------------------------------------------------
    assign w_r     = r_shift[15:5];
    // 12 bits so that negating -1024 yields +1024 instead of wrapping.
    assign w_r_ext = {w_r[10], w_r};
    assign w_a     = w_r[10] ? -w_r_ext : w_r_ext;
    // w_a is never negative here, so a logical shift truncates toward zero.
    assign w_m     = $unsigned(w_a) >> 2;

    // -------------------------------------------------------------------------
    // Sequencer next-state logic
    // -------------------------------------------------------------------------
    assign w_div_done = (r_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_shift_en  = 1'b0;
        w_bit_inc   = 1'b0;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (EN) begin
                    w_state_nxt = S_SETUP;
                end
            end

            S_SETUP: begin
                if (w_div_done) begin
                    w_state_nxt = S_SCK_HI;
                    w_shift_en  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_SCK_HI: begin
                if (w_div_done) begin
                    w_state_nxt = S_SCK_LO;
                    w_bit_inc   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_SCK_LO: begin
                if (w_div_done) begin
                    if (r_bitcnt < BITS_ALL) begin
                        w_state_nxt = S_SCK_HI;
                        w_shift_en  = 1'b1;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (w_div_done) begin
                    w_state_nxt = S_CONVERT;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_CONVERT: begin
                w_load      = 1'b1;
                w_state_nxt = S_GAP;
            end

            S_GAP: begin
                // EN is only looked at here, so a frame is never cut short
                // and a mid-gap EN change waits for the gap to finish.
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = EN ? S_SETUP : S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencer state, phase counter and bit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_state_nxt == S_SETUP) begin
                r_bitcnt <= '0;
            end else if (w_bit_inc) begin
                r_bitcnt <= r_bitcnt + BIT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Serial pins and shift register
    // -------------------------------------------------------------------------
    // CS/SCK are registered from the next state so the pins change cleanly on
    // the clock edge; SIO is captured on the edge that raises SCK.
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
            r_busy  <= 1'b0;
            r_shift <= '0;
        end else begin
            r_cs   <= !(w_state_nxt inside {S_SETUP, S_SCK_HI, S_SCK_LO, S_HOLD});
            r_sck  <= (w_state_nxt == S_SCK_HI);
            r_busy <= (w_state_nxt != S_IDLE);
            if (w_shift_en) begin
                r_shift <= {r_shift[RAW_W-2:0], SIO};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result registers, loaded once per completed frame
    // -------------------------------------------------------------------------
    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_raw   <= '0;
            r_neg   <= 1'b0;
            r_mag   <= '0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_load;
            if (w_load) begin
                r_raw <= r_shift;
                r_neg <= f_sign(w_r[10], w_m);
                r_mag <= f_sat_mag(w_m);
                r_sat <= f_sat_flag(w_m);
            end
        end
    end

    assign CS         = r_cs;
    assign SCK        = r_sck;
    assign BUSY       = r_busy;
    assign RAW        = r_raw;
    assign TEMP_NEG   = r_neg;
    assign TEMP_MAG   = r_mag;
    assign TEMP_SAT   = r_sat;
    assign TEMP_VALID = r_valid;

endmodule
